// File: rtl/fetch_pkg.sv
// Shared fetch-side types: FIFO entry bundle and the canonical NOP.
// Imported by the prefetch unit, its FIFO and decode.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries between imem return and decode.
// Flush beats push; head is read straight from registered storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: sequential imem reads, return FIFO, redirect flush.
// Stale responses after a redirect are counted off via discard_q.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_tgt;
  logic          issue, drop, push, pop;
  logic          fifo_empty, fifo_full_unused;
  fetch_entry_t  push_entry, head;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign occupancy    = {1'b0, fifo_count} + {1'b0, inflight_q};

  // Gated by n_rst so the request drops the moment reset asserts
  assign imem_req  = n_rst && !redirect_valid &&
                     (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;

  assign drop = imem_rvalid && (discard_q != '0);
  assign push = imem_rvalid && !drop && !redirect_valid;
  assign push_entry = '{pc: pc_q, instr: imem_rdata};

  assign instr_valid = !fifo_empty && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;

  always_comb begin
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);
    discard_d  = discard_q - CW'(drop);
    fetch_pc_d = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    pc_d       = push ? pc_q + 32'd4 : pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      pc_d       = redirect_tgt;
      discard_d  = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order imem model
// and a scoreboard of issued PCs checked at each decode handshake.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  fetch_prefetch_unit dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          first_valid = -1;
  int          niss = 0;
  int          npop = 0;
  int          base;
  logic        mem_en = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_q [$];
  logic [31:0] mem_q [$];
  logic [31:0] pop_log [$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (pop_log.size() > i) ? pop_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    imem_rvalid = mem_en && (mem_q.size() > 0);
    imem_rdata  = imem_rvalid ? mdata(mem_q[0]) : 32'h0;
  endtask

  task automatic cycle();
    logic        iss;
    logic [31:0] ia;
    logic [31:0] e;
    @(negedge clk);
    iss = imem_req && imem_gnt;
    ia  = imem_addr;
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_data", instr_data, mdata(e));
      end
      pop_log.push_back(instr_pc);
      npop++;
    end
    if (iss) begin
      chk("issue_addr", ia, exp_pc);
      exp_pc = exp_pc + 32'd4;
      exp_q.push_back(ia);
      niss++;
    end
    if (redirect_valid) begin
      chk("redir_valid_low", {31'b0, instr_valid}, 32'd0);
      exp_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    if (instr_valid && first_valid < 0) first_valid = cyc;
    @(posedge clk);
    #1;
    if (imem_rvalid) void'(mem_q.pop_front());
    if (iss) mem_q.push_back(ia);
    drive_mem();
    cyc++;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},    32'd0);
    chk({tag, "_addr"},  imem_addr,            32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_data"},  instr_data,           32'h0);
    chk({tag, "_pc"},    instr_pc,             32'h0);
  endtask

  initial begin
    n_rst = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    #12;
    chk_reset_outputs("rst");

    // Streaming from reset with a 1-cycle memory
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    imem_gnt = 1'b1;
    instr_ready = 1'b1;
    mem_en = 1'b1;
    cyc = 0;
    first_valid = -1;
    npop = 0;
    for (int i = 0; i < 12; i++) cycle();
    chk("t1_first_valid", 32'(first_valid), 32'd2);
    chk("t1_pops", 32'(npop), 32'd10);

    // Backpressure: four issues then req drops
    instr_ready = 1'b0;
    redirect(32'h0);
    base = niss;
    for (int i = 0; i < 8; i++) cycle();
    chk("t2_issues", 32'(niss - base), 32'd4);
    chk("t2_req_low", {31'b0, imem_req}, 32'd0);
    chk("t2_head_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_head_pc", instr_pc, 32'h0);
    pop_log.delete();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_pop0", log_at(0), 32'h0);
    chk("t2_pop3", log_at(3), 32'hC);
    chk("t2_pop4", log_at(4), 32'h10);
    chk("t2_npop", 32'(pop_log.size()), 32'd6);

    // Grant stall: address must hold
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_req", {31'b0, imem_req}, 32'd1);
      chk("t3_addr_hold", imem_addr, exp_pc);
      cycle();
    end
    imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Redirect with two requests outstanding
    imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    mem_en = 1'b0;
    drive_mem();
    imem_gnt = 1'b1;
    base = niss;
    cycle();
    cycle();
    chk("t4_inflight_issues", 32'(niss - base), 32'd2);
    redirect(32'h100);
    chk("t4_empty_after", {31'b0, instr_valid}, 32'd0);
    mem_en = 1'b1;
    drive_mem();
    pop_log.delete();
    for (int i = 0; i < 10; i++) cycle();
    chk("t4_first_pc", log_at(0), 32'h100);
    chk("t4_second_pc", log_at(1), 32'h104);

    // Redirect colliding with rvalid and a pending pop
    for (int i = 0; i < 4; i++) cycle();
    chk("t5_rvalid_pre", {31'b0, imem_rvalid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("t5_valid_forced", {31'b0, instr_valid}, 32'd0);
    chk("t5_req_blocked", {31'b0, imem_req}, 32'd0);
    cycle();
    redirect_valid = 1'b0;
    pop_log.delete();
    for (int i = 0; i < 6; i++) cycle();
    chk("t5_first_pc", log_at(0), 32'h100);

    // Async reset with three buffered entries
    instr_ready = 1'b0;
    imem_gnt = 1'b0;
    redirect(32'h200);
    imem_gnt = 1'b1;
    base = niss;
    for (int i = 0; i < 3; i++) cycle();
    imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t6_issues", 32'(niss - base), 32'd3);
    chk("t6_head_pc", instr_pc, 32'h200);
    chk("t6_head_data", instr_data, mdata(32'h200));
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    mem_q.delete();
    exp_q.delete();
    pop_log.delete();
    exp_pc = 32'h0;
    mem_en = 1'b0;
    drive_mem();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    mem_en = 1'b1;
    imem_gnt = 1'b1;
    instr_ready = 1'b1;
    cyc = 0;
    first_valid = -1;
    for (int i = 0; i < 8; i++) cycle();
    chk("t6_first_valid", 32'(first_valid), 32'd2);
    chk("t6_first_pc", log_at(0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
